// File: rtl/sram_val_rdy_1p.sv
// Single-port SRAM with val/rdy request and response ports, per-byte write mask and a
// 2-entry response buffer so callers can apply backpressure without losing responses.
module sram_val_rdy_1p #(
  parameter int unsigned p_data_nbits   = 128,
  parameter int unsigned p_num_entries  = 256,
  parameter int unsigned p_opaque_nbits = 8,
  localparam int unsigned c_addr_nbits  = (p_num_entries > 1) ? $clog2(p_num_entries) : 1,
  localparam int unsigned c_mask_nbits  = p_data_nbits / 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_val,
  output logic                      req_rdy,
  input  logic                      req_type,
  input  logic [c_addr_nbits-1:0]   req_addr,
  input  logic [p_data_nbits-1:0]   req_data,
  input  logic [c_mask_nbits-1:0]   req_wmask,
  input  logic [p_opaque_nbits-1:0] req_opaque,
  output logic                      resp_val,
  input  logic                      resp_rdy,
  output logic                      resp_type,
  output logic [p_opaque_nbits-1:0] resp_opaque,
  output logic [p_data_nbits-1:0]   resp_data
);

  logic [p_data_nbits-1:0] mem [p_num_entries];

  logic                      req_fire;
  logic                      resp_fire;
  logic                      in_range;
  logic                      enq;
  logic                      deq;
  logic [1:0]                outstanding;

  logic                      s1_val_q, s1_val_d;
  logic                      s1_type_q;
  logic [p_opaque_nbits-1:0] s1_opaque_q;
  logic [p_data_nbits-1:0]   s1_data_q;

  logic                      q_type_q   [2];
  logic [p_opaque_nbits-1:0] q_opaque_q [2];
  logic [p_data_nbits-1:0]   q_data_q   [2];
  logic                      head_q, head_d;
  logic                      tail_q, tail_d;
  logic [1:0]                count_q, count_d;

  // Handshake and credit logic; reset forces the idle handshake state.
  always_comb begin
    in_range    = 32'(req_addr) < p_num_entries;
    resp_val    = reset_n & (s1_val_q | (count_q != 2'd0));
    resp_fire   = resp_val & resp_rdy;
    outstanding = count_q + {1'b0, s1_val_q};
    req_rdy     = ~reset_n | (outstanding < 2'd2) | resp_fire;
    req_fire    = reset_n & req_val & req_rdy;
  end

  // S1 bypasses the queue only when the queue is empty.
  always_comb begin
    resp_type   = 1'b0;
    resp_opaque = '0;
    resp_data   = '0;
    if (resp_val) begin
      if (count_q == 2'd0) begin
        resp_type   = s1_type_q;
        resp_opaque = s1_opaque_q;
        resp_data   = s1_data_q;
      end else begin
        resp_type   = q_type_q[head_q];
        resp_opaque = q_opaque_q[head_q];
        resp_data   = q_data_q[head_q];
      end
    end
  end

  always_comb begin
    enq      = s1_val_q & ~((count_q == 2'd0) & resp_fire);
    deq      = resp_fire & (count_q != 2'd0);
    count_d  = count_q + 2'(enq) - 2'(deq);
    head_d   = head_q ^ deq;
    tail_d   = tail_q ^ enq;
    s1_val_d = req_fire;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_val_q <= 1'b0;
      count_q  <= 2'd0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
    end else begin
      s1_val_q <= s1_val_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  // Payload registers carry no reset; validity is tracked by s1_val_q and count_q.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      s1_type_q   <= req_type;
      s1_opaque_q <= req_opaque;
      s1_data_q   <= (!req_type && in_range) ? mem[req_addr] : '0;
    end
    if (enq) begin
      q_type_q[tail_q]   <= s1_type_q;
      q_opaque_q[tail_q] <= s1_opaque_q;
      q_data_q[tail_q]   <= s1_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire && req_type && in_range) begin
      for (int i = 0; i < int'(c_mask_nbits); i++) begin
        if (req_wmask[i]) mem[req_addr][8*i +: 8] <= req_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_val_rdy_1p.sv
// Bench for sram_val_rdy_1p: table-driven requests, scoreboard of expected responses,
// hand-written sequences for reset, backpressure, throughput and reset-while-busy.
module tb_sram_val_rdy_1p;

  localparam int unsigned DW = 128;
  localparam int unsigned NE = 200;
  localparam int unsigned OW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned MW = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_val, req_rdy, req_type;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [MW-1:0] req_wmask;
  logic [OW-1:0] req_opaque;
  logic          resp_val, resp_rdy, resp_type;
  logic [OW-1:0] resp_opaque;
  logic [DW-1:0] resp_data;

  sram_val_rdy_1p #(
    .p_data_nbits  (DW),
    .p_num_entries (NE),
    .p_opaque_nbits(OW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_wmask  (req_wmask),
    .req_opaque (req_opaque),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_type  (resp_type),
    .resp_opaque(resp_opaque),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          typ;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] wmask;
    logic [OW-1:0] opaque;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic          typ;
    logic [OW-1:0] opaque;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] drv_exp;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic          tp_on    = 1'b0;
  int            tp_cnt   = 0;
  int            tp_first = 0;
  int            tp_last  = 0;
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_opaque;
  logic [DW-1:0] prev_data;

  function void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop/compare responses, hold-stability under backpressure, push accepted requests.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_val", DW'(resp_val), DW'(1'b1));
        check("hold_opaque", DW'(resp_opaque), DW'(prev_opaque));
        check("hold_data", resp_data, prev_data);
      end
      if (resp_val && resp_rdy) begin
        if (tp_on) begin
          tp_cnt++;
          if (tp_cnt == 1) tp_first = cyc;
          tp_last = cyc;
        end
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got opaque %0h, required no response", resp_opaque);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_type", DW'(resp_type), DW'(e.typ));
          check("resp_opaque", DW'(resp_opaque), DW'(e.opaque));
          check("resp_data", resp_data, e.data);
        end
      end
      prev_stall  = resp_val & ~resp_rdy;
      prev_opaque = resp_opaque;
      prev_data   = resp_data;
      if (req_val && req_rdy) sb.push_back('{req_type, req_opaque, drv_exp});
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request fires.
  task automatic send(input vec_t v);
    int w = 0;
    req_val    = 1'b1;
    req_type   = v.typ;
    req_addr   = v.addr;
    req_data   = v.data;
    req_wmask  = v.wmask;
    req_opaque = v.opaque;
    drv_exp    = v.exp;
    @(negedge clk);
    while (!req_rdy && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!req_rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: got req_rdy=0 for 50 cycles, required 1 (opaque %0h)",
               v.opaque);
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", DW'(sb.size()), DW'(0));
  endtask

  function automatic vec_t rd(logic [AW-1:0] a, logic [OW-1:0] t, logic [DW-1:0] e);
    rd = '{1'b0, a, '0, '0, t, e};
  endfunction

  function automatic vec_t wr(logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m,
                              logic [OW-1:0] t);
    wr = '{1'b1, a, d, m, t, '0};
  endfunction

  vec_t tbl [13];
  vec_t bp  [4];

  initial begin
    logic [DW-1:0] ones;
    logic [DW-1:0] v7a;
    logic [DW-1:0] v7b;
    int            c0;
    ones = '1;
    v7a  = {{120{1'b1}}, 8'h00};
    v7b  = {{112{1'b1}}, 16'h5500};

    tbl[0]  = wr(8'd5, 128'h00112233, 16'hFFFF, 8'h10);
    tbl[1]  = rd(8'd5, 8'h11, 128'h00112233);
    tbl[2]  = wr(8'd7, ones, 16'hFFFF, 8'h12);
    tbl[3]  = wr(8'd7, '0, 16'h0001, 8'h13);
    tbl[4]  = rd(8'd7, 8'h14, v7a);
    tbl[5]  = wr(8'd7, 128'h5500, 16'h0002, 8'h15);
    tbl[6]  = rd(8'd7, 8'h16, v7b);
    tbl[7]  = wr(8'd5, ones, 16'h0000, 8'h17);
    tbl[8]  = rd(8'd5, 8'h18, 128'h00112233);
    tbl[9]  = wr(8'd199, 128'hC0FFEE, 16'hFFFF, 8'h19);
    tbl[10] = rd(8'd199, 8'h1A, 128'hC0FFEE);
    tbl[11] = wr(8'd250, 128'hDEAD, 16'hFFFF, 8'h1B);
    tbl[12] = rd(8'd250, 8'h1C, '0);

    bp[0] = rd(8'd5, 8'd1, 128'h00112233);
    bp[1] = rd(8'd7, 8'd2, v7b);
    bp[2] = rd(8'd5, 8'd3, 128'h00112233);
    bp[3] = rd(8'd7, 8'd4, v7b);

    // Reset held with a pending request: nothing may be accepted.
    reset_n    = 1'b0;
    resp_rdy   = 1'b1;
    req_val    = 1'b1;
    req_type   = 1'b0;
    req_addr   = 8'd5;
    req_data   = '0;
    req_wmask  = '0;
    req_opaque = 8'hEE;
    drv_exp    = '0;
    repeat (3) begin
      @(negedge clk);
      check("rst_resp_val", DW'(resp_val), DW'(1'b0));
      check("rst_req_rdy", DW'(req_rdy), DW'(1'b1));
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    req_val = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_resp_val", DW'(resp_val), DW'(1'b0));
    end
    @(posedge clk);
    #1;

    // Table: write/read, byte masks, zero mask, boundary and out-of-range addresses.
    for (int i = 0; i < 13; i++) send(tbl[i]);
    drain();

    // Backpressure: only two requests accepted while resp_rdy is low.
    resp_rdy = 1'b0;
    send(bp[0]);
    send(bp[1]);
    req_val    = 1'b1;
    req_type   = bp[2].typ;
    req_addr   = bp[2].addr;
    req_opaque = bp[2].opaque;
    drv_exp    = bp[2].exp;
    repeat (3) begin
      @(negedge clk);
      check("bp_req_rdy", DW'(req_rdy), DW'(1'b0));
      check("bp_head_opaque", DW'(resp_opaque), DW'(8'd1));
    end
    check("bp_accepted", DW'(sb.size()), DW'(2));
    @(posedge clk);
    #1;
    resp_rdy = 1'b1;
    send(bp[2]);
    send(bp[3]);
    drain();

    // Throughput: 64 back-to-back reads, one response per cycle.
    for (int i = 0; i < 64; i++) send(wr(AW'(100 + i), DW'(32'hA500_0000 + i), '1, OW'(i)));
    drain();
    tp_on = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 64; i++) send(rd(AW'(100 + i), OW'(i), DW'(32'hA500_0000 + i)));
    check("tp_req_cycles", DW'(cyc - c0), DW'(64));
    drain();
    tp_on = 1'b0;
    check("tp_resp_count", DW'(tp_cnt), DW'(64));
    check("tp_resp_span", DW'(tp_last - tp_first), DW'(63));

    // Reset with two responses buffered: both dropped, array contents kept.
    resp_rdy = 1'b0;
    send(rd(8'd5, 8'h61, 128'h00112233));
    send(rd(8'd7, 8'h62, v7b));
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    resp_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_resp_val", DW'(resp_val), DW'(1'b0));
      check("midrst_req_rdy", DW'(req_rdy), DW'(1'b1));
    end
    @(posedge clk);
    #1;
    send(rd(8'd5, 8'h71, 128'h00112233));
    send(rd(8'd250, 8'h72, '0));
    send(rd(8'd200, 8'h73, '0));
    send(rd(8'd199, 8'h74, 128'hC0FFEE));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
